// File: rtl/vga_write_arbiter_pkg.sv
// Shared constants and state encoding for the VGA drawing path
// (arbiter, player and obstacle objects all draw into the same frame).
package vga_write_arbiter_pkg;

   localparam int C_NX          = 10;   // X coordinate width
   localparam int C_NY          = 9;    // Y coordinate width
   localparam int C_COLOR_DEPTH = 9;    // pixel colour width
   localparam int C_H_RES       = 640;  // visible columns
   localparam int C_V_RES       = 480;  // visible rows

   // Arbiter states: waiting for a requester, or streaming one owner's pixels
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_e;

endpackage

// File: rtl/vga_write_arbiter_rr_pick.sv
// Round-robin selector: finds the first requester at or after ptr+1
// (wrapping modulo N_REQ) and returns it as one-hot plus index.
module vga_write_arbiter_rr_pick
   import vga_write_arbiter_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [2:0]       i_ptr,
   output logic [N_REQ-1:0] o_pick,
   output logic [2:0]       o_idx,
   output logic             o_valid
);

   localparam logic [N_REQ-1:0] L_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

   // w_cand[gi] is the requester examined gi-th in priority order
   logic [2:0]       w_cand [N_REQ];
   logic [N_REQ-1:0] w_hit;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_cand
         logic [4:0] w_sum;
         // ptr is always below N_REQ, so a single subtraction wraps the sum
         assign w_sum       = 5'(i_ptr) + 5'd1 + 5'(gi);
         assign w_cand[gi]  = (w_sum >= 5'(N_REQ)) ? 3'(w_sum - 5'(N_REQ)) : 3'(w_sum);
         assign w_hit[gi]   = |(i_req & (L_ONE << w_cand[gi]));
      end
   endgenerate

   // Lowest search position with an active request wins
   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            o_valid = 1'b1;
            o_idx   = w_cand[i];
         end
      end
      o_pick = o_valid ? (L_ONE << o_idx) : '0;
   end

endmodule

// File: rtl/vga_write_arbiter.sv
// Arbitrates several pixel streams onto one VGA adapter write port.
// A grant is held for a whole sprite burst (until last or MAX_BURST cycles);
// off-screen pixels are swallowed and counted instead of written.
module vga_write_arbiter
   import vga_write_arbiter_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int nX          = C_NX,
   parameter int nY          = C_NY,
   parameter int COLOR_DEPTH = C_COLOR_DEPTH,
   parameter int MAX_BURST   = 1024,
   parameter int H_RES       = C_H_RES,
   parameter int V_RES       = C_V_RES
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [N_REQ-1:0]             i_req,
   input  logic [N_REQ-1:0]             i_last,
   input  logic [N_REQ*nX-1:0]          i_px_x,
   input  logic [N_REQ*nY-1:0]          i_px_y,
   input  logic [N_REQ*COLOR_DEPTH-1:0] i_px_color,
   output logic [N_REQ-1:0]             o_gnt,
   output logic [nX-1:0]                o_vga_x,
   output logic [nY-1:0]                o_vga_y,
   output logic [COLOR_DEPTH-1:0]       o_vga_color,
   output logic                         o_vga_write,
   output logic [2:0]                   o_owner,
   output logic                         o_busy,
   output logic [15:0]                  o_clip_cnt
);

   localparam int               CNT_W      = $clog2(MAX_BURST) + 1;
   localparam logic [CNT_W-1:0] L_CNT_LAST = CNT_W'(MAX_BURST - 1);
   localparam logic [nX:0]      L_H_RES    = (nX + 1)'(H_RES);
   localparam logic [nY:0]      L_V_RES    = (nY + 1)'(V_RES);

   arb_state_e             r_state;
   logic [N_REQ-1:0]       r_gnt;
   logic [2:0]             r_owner;
   logic [2:0]             r_ptr;
   logic                   r_busy;
   logic [CNT_W-1:0]       r_burst_cnt;
   logic [nX-1:0]          r_vga_x;
   logic [nY-1:0]          r_vga_y;
   logic [COLOR_DEPTH-1:0] r_vga_color;
   logic                   r_vga_write;
   logic [15:0]            r_clip_cnt;

   logic [N_REQ-1:0]       w_pick;
   logic [2:0]             w_pick_idx;
   logic                   w_pick_valid;
   logic [nX-1:0]          w_x;
   logic [nY-1:0]          w_y;
   logic [COLOR_DEPTH-1:0] w_color;
   logic                   w_accept;
   logic                   w_last;
   logic                   w_in_frame;
   logic                   w_release;

   vga_write_arbiter_rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .i_req   (i_req),
      .i_ptr   (r_ptr),
      .o_pick  (w_pick),
      .o_idx   (w_pick_idx),
      .o_valid (w_pick_valid)
   );

   // Select the owner's pixel; r_gnt is one-hot so non-owners never leak through
   always_comb begin
      w_x     = '0;
      w_y     = '0;
      w_color = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (r_gnt[k]) begin
            w_x     = i_px_x[k*nX +: nX];
            w_y     = i_px_y[k*nY +: nY];
            w_color = i_px_color[k*COLOR_DEPTH +: COLOR_DEPTH];
         end
      end
   end

   assign w_accept   = (r_state == ST_BURST) && (|(i_req & r_gnt));
   assign w_last     = |(i_last & r_gnt);
   assign w_in_frame = ({1'b0, w_x} < L_H_RES) && ({1'b0, w_y} < L_V_RES);
   // The counter-based release fires whether or not a pixel arrives that cycle
   assign w_release  = (r_state == ST_BURST) &&
                       ((w_accept && w_last) || (r_burst_cnt == L_CNT_LAST));

   // Grant FSM: pick in IDLE, hold the owner through BURST until last or timeout
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_gnt       <= '0;
         r_owner     <= '0;
         r_busy      <= 1'b0;
         r_burst_cnt <= '0;
         r_ptr       <= 3'(N_REQ - 1);
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pick_valid) begin
                  r_state     <= ST_BURST;
                  r_gnt       <= w_pick;
                  r_owner     <= w_pick_idx;
                  r_busy      <= 1'b1;
                  r_burst_cnt <= '0;
               end
            end
            ST_BURST: begin
               r_burst_cnt <= r_burst_cnt + 1'b1;
               if (w_release) begin
                  r_state <= ST_IDLE;
                  r_gnt   <= '0;
                  r_busy  <= 1'b0;
                  r_ptr   <= r_owner;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_gnt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Output pixel register: write in-frame pixels, count clipped ones
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vga_x     <= '0;
         r_vga_y     <= '0;
         r_vga_color <= '0;
         r_vga_write <= 1'b0;
         r_clip_cnt  <= '0;
      end else begin
         r_vga_write <= w_accept && w_in_frame;
         if (w_accept && w_in_frame) begin
            r_vga_x     <= w_x;
            r_vga_y     <= w_y;
            r_vga_color <= w_color;
         end
         if (w_accept && !w_in_frame && (r_clip_cnt != 16'hFFFF)) begin
            r_clip_cnt <= r_clip_cnt + 16'd1;
         end
      end
   end

   assign o_gnt       = r_gnt;
   assign o_owner     = r_owner;
   assign o_busy      = r_busy;
   assign o_vga_x     = r_vga_x;
   assign o_vga_y     = r_vga_y;
   assign o_vga_color = r_vga_color;
   assign o_vga_write = r_vga_write;
   assign o_clip_cnt  = r_clip_cnt;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Scoreboard bench for vga_write_arbiter: requester models feed pixel
// queues, expected grants/writes are queued by hand, a negedge monitor checks.
module tb_vga_write_arbiter;
   import vga_write_arbiter_pkg::*;

   localparam int N   = 4;
   localparam int NXW = 10;
   localparam int NYW = 9;
   localparam int CD  = 9;

   typedef struct packed {
      logic [NXW-1:0] x;
      logic [NYW-1:0] y;
      logic [CD-1:0]  c;
      logic           l;
   } pix_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [N-1:0]     req, last;
   logic [N*NXW-1:0] px_x;
   logic [N*NYW-1:0] px_y;
   logic [N*CD-1:0]  px_c;
   logic [N-1:0]     hold;
   logic             sel8;

   logic [N-1:0] a_gnt, b_gnt;
   logic [NXW-1:0] a_x, b_x;
   logic [NYW-1:0] a_y, b_y;
   logic [CD-1:0] a_c, b_c;
   logic a_wr, b_wr, a_busy, b_busy;
   logic [2:0] a_own, b_own;
   logic [15:0] a_clip, b_clip;

   logic [N-1:0] m_gnt;
   logic [NXW-1:0] m_x;
   logic [NYW-1:0] m_y;
   logic [CD-1:0] m_c;
   logic m_wr, m_busy;
   logic [2:0] m_own;
   logic [15:0] m_clip;

   pix_t src_q [N][$];
   pix_t exp_pix[$];
   int   exp_gnt[$];
   pix_t hold_exp;
   logic [N-1:0] prev_gnt;
   int   idle_cnt;
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_writes = 0;

   always #5 clk = ~clk;

   vga_write_arbiter #(.N_REQ(N)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_last(last),
      .i_px_x(px_x), .i_px_y(px_y), .i_px_color(px_c),
      .o_gnt(a_gnt), .o_vga_x(a_x), .o_vga_y(a_y), .o_vga_color(a_c),
      .o_vga_write(a_wr), .o_owner(a_own), .o_busy(a_busy), .o_clip_cnt(a_clip)
   );

   vga_write_arbiter #(.N_REQ(N), .MAX_BURST(8)) u_dut8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_last(last),
      .i_px_x(px_x), .i_px_y(px_y), .i_px_color(px_c),
      .o_gnt(b_gnt), .o_vga_x(b_x), .o_vga_y(b_y), .o_vga_color(b_c),
      .o_vga_write(b_wr), .o_owner(b_own), .o_busy(b_busy), .o_clip_cnt(b_clip)
   );

   assign m_gnt  = sel8 ? b_gnt  : a_gnt;
   assign m_x    = sel8 ? b_x    : a_x;
   assign m_y    = sel8 ? b_y    : a_y;
   assign m_c    = sel8 ? b_c    : a_c;
   assign m_wr   = sel8 ? b_wr   : a_wr;
   assign m_busy = sel8 ? b_busy : a_busy;
   assign m_own  = sel8 ? b_own  : a_own;
   assign m_clip = sel8 ? b_clip : a_clip;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expected writes/grants whenever the DUT presents them
   always @(negedge clk) begin : monitor
      pix_t e;
      int   g;
      if (!rst_n) begin
         hold_exp = '0;
         prev_gnt = '0;
         idle_cnt = 1;
      end else begin
         if (m_wr) begin
            n_writes++;
            if (exp_pix.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got (%0d,%0d,%0h) expected none", m_x, m_y, m_c);
            end else begin
               e = exp_pix.pop_front();
               check("vga_pixel", {m_x, m_y, m_c}, {e.x, e.y, e.c});
               hold_exp = e;
            end
         end else begin
            check("vga_hold", {m_x, m_y, m_c}, {hold_exp.x, hold_exp.y, hold_exp.c});
         end
         check("gnt_onehot0", 32'($onehot0(m_gnt)), 1);
         check("busy_vs_gnt", m_busy, 32'(m_gnt != 0));
         if (prev_gnt == 0 && m_gnt != 0) begin
            check("idle_gap", 32'(idle_cnt >= 1), 1);
            if (exp_gnt.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_grant: got %b expected none", m_gnt);
            end else begin
               g = exp_gnt.pop_front();
               check("grant", m_gnt, 32'(1) << g);
               check("owner", m_own, g);
            end
            idle_cnt = 0;
         end
         if (m_gnt == 0) idle_cnt++;
         prev_gnt = m_gnt;
      end
   end

   task automatic add(input int k, input int x, input int y, input int c, input bit l);
      pix_t p;
      p.x = NXW'(x); p.y = NYW'(y); p.c = CD'(c); p.l = l;
      src_q[k].push_back(p);
   endtask

   task automatic expw(input int x, input int y, input int c);
      pix_t p;
      p.x = NXW'(x); p.y = NYW'(y); p.c = CD'(c); p.l = 1'b0;
      exp_pix.push_back(p);
   endtask

   // Present each requester's queue head (or nothing) on the input buses
   task automatic drive();
      pix_t p;
      for (int k = 0; k < N; k++) begin
         if (src_q[k].size() > 0 && !hold[k]) begin
            p = src_q[k][0];
            req[k] = 1'b1;
            last[k] = p.l;
            px_x[k*NXW +: NXW] = p.x;
            px_y[k*NYW +: NYW] = p.y;
            px_c[k*CD +: CD]   = p.c;
         end else begin
            req[k] = 1'b0;
            last[k] = 1'b0;
         end
      end
   endtask

   // One clock: a requester's head pixel is consumed if it was granted and valid
   task automatic step();
      logic [N-1:0] acc;
      acc = m_gnt & req;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++)
         if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      drive();
   endtask

   task automatic wait_done(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         step();
         done = (src_q[0].size() == 0) && (src_q[1].size() == 0) &&
                (src_q[2].size() == 0) && (src_q[3].size() == 0) &&
                !m_busy && (exp_pix.size() == 0) && (exp_gnt.size() == 0);
      end
      check(name, 32'(done), 1);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int cnt;
      int w0;
      req = '0; last = '0; px_x = '0; px_y = '0; px_c = '0; hold = '0; sel8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      // Reset state
      check("rst_gnt", a_gnt, 0);
      check("rst_write", a_wr, 0);
      check("rst_busy", a_busy, 0);
      check("rst_owner", a_own, 0);
      check("rst_clip", a_clip, 0);
      check("rst_pixel", {a_x, a_y, a_c}, 0);
      rst_n = 1'b1;

      // Single pixel with last from requester 0
      add(0, 100, 200, 'h1C0, 1); exp_gnt.push_back(0); expw(100, 200, 'h1C0);
      drive();
      step();
      check("t1_gnt_lat", m_gnt, 4'b0001);
      step();
      check("t1_write_lat", m_wr, 1);
      check("t1_released", m_gnt, 0);
      check("t1_idle", m_busy, 0);
      wait_done("t1_done");

      // All four request together, 2-pixel bursts, requester 0 twice
      pulse_reset();
      add(0, 10, 10, 1, 0); add(0, 11, 10, 2, 1); add(0, 12, 10, 3, 0); add(0, 13, 10, 4, 1);
      add(1, 20, 20, 'h11, 0); add(1, 21, 20, 'h12, 1);
      add(2, 30, 30, 'h21, 0); add(2, 31, 30, 'h22, 1);
      add(3, 40, 40, 'h31, 0); add(3, 41, 40, 'h32, 1);
      foreach (exp_gnt[i]) ;
      exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(2);
      exp_gnt.push_back(3); exp_gnt.push_back(0);
      expw(10, 10, 1); expw(11, 10, 2); expw(20, 20, 'h11); expw(21, 20, 'h12);
      expw(30, 30, 'h21); expw(31, 30, 'h22); expw(40, 40, 'h31); expw(41, 40, 'h32);
      expw(12, 10, 3); expw(13, 10, 4);
      drive();
      repeat (14) step();
      check("t2_last_burst", m_gnt, 4'b0001);
      step();
      check("t2_end_cycle", m_busy, 0);
      wait_done("t2_done");

      // Owner 2 pauses mid-burst; requester 0 must wait
      add(2, 50, 60, 'hA1, 0); add(2, 51, 60, 'hA2, 0); add(2, 52, 60, 'hA3, 0); add(2, 53, 60, 'hA4, 1);
      exp_gnt.push_back(2); exp_gnt.push_back(0);
      expw(50, 60, 'hA1); expw(51, 60, 'hA2); expw(52, 60, 'hA3); expw(53, 60, 'hA4);
      expw(70, 70, 'h55);
      drive();
      step();
      check("t3_gnt2", m_gnt, 4'b0100);
      repeat (3) step();
      hold[2] = 1'b1;
      add(0, 70, 70, 'h55, 1);
      drive();
      for (int i = 0; i < 5; i++) begin
         step();
         check("t3_gnt_held", m_gnt, 4'b0100);
      end
      hold[2] = 1'b0;
      drive();
      wait_done("t3_done");

      // Clipping: two off-screen pixels then the last visible corner
      add(3, 640, 10, 'h1FF, 0); add(3, 5, 480, 'h1FE, 0); add(3, 639, 479, 'h1FD, 1);
      exp_gnt.push_back(3); expw(639, 479, 'h1FD);
      drive();
      wait_done("t4_done");
      check("t4_clip_cnt", m_clip, 2);

      // Asynchronous reset in the middle of a 10-pixel burst
      for (int i = 0; i < 10; i++) add(1, 100 + i, 100, i, i == 9);
      exp_gnt.push_back(1);
      expw(100, 100, 0); expw(101, 100, 1); expw(102, 100, 2);
      drive();
      repeat (4) step();
      #6;
      rst_n = 1'b0;
      #1;
      check("t5_async_write", m_wr, 0);
      check("t5_async_gnt", m_gnt, 0);
      check("t5_async_busy", m_busy, 0);
      check("t5_async_clip", m_clip, 0);
      for (int k = 0; k < N; k++) src_q[k].delete();
      add(3, 200, 201, 'h33, 1); add(1, 300, 301, 'h44, 1);
      exp_gnt.push_back(1); exp_gnt.push_back(3);
      expw(300, 301, 'h44); expw(200, 201, 'h33);
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_done("t5_done");

      // Forced release after MAX_BURST=8 cycles on the second instance
      rst_n = 1'b0;
      sel8 = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         add(1, 400 + i, 300, 'h10 + i, 0);
         expw(400 + i, 300, 'h10 + i);
      end
      add(2, 500, 400, 'h77, 1); expw(500, 400, 'h77);
      exp_gnt.push_back(1); exp_gnt.push_back(2);
      w0 = n_writes;
      cnt = 0;
      drive();
      for (int i = 0; i < 60; i++) begin
         step();
         if (m_gnt == 4'b0010) cnt++;
      end
      check("t6_burst_len", cnt, 8);
      check("t6_write_cnt", n_writes - w0, 9);
      check("t6_pix_drained", exp_pix.size(), 0);
      check("t6_gnt_drained", exp_gnt.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_write_arbiter.md
VGA_WRITE_ARBITER -- requirements
Module: vga_write_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of drawing requesters (2..8).
REQ-002 Parameter nX, default 10, SHALL set the X coordinate width.
REQ-003 Parameter nY, default 9, SHALL set the Y coordinate width.
REQ-004 Parameter COLOR_DEPTH, default 9, SHALL set the pixel colour width.
REQ-005 Parameter MAX_BURST, default 1024, SHALL set the maximum number of cycles one grant is held.
REQ-006 Parameters H_RES and V_RES, defaults 640 and 480, SHALL set the visible frame for clipping.
REQ-007 Clock  in  1  single clock; all logic on the rising edge.
REQ-008 Resetn  in  1  asynchronous, active-low reset.
REQ-009 req  in  N_REQ  per-requester pixel-valid / draw request.
REQ-010 last  in  N_REQ  per-requester marker for the final pixel of a sprite burst.
REQ-011 px_x  in  N_REQ*nX  packed X coordinates, requester k in slice k.
REQ-012 px_y  in  N_REQ*nY  packed Y coordinates.
REQ-013 px_color  in  N_REQ*COLOR_DEPTH  packed pixel colours.
REQ-014 gnt  out  N_REQ  one-hot registered grant.
REQ-015 VGA_x, VGA_y, VGA_color  out  nX/nY/COLOR_DEPTH  registered pixel to the VGA adapter.
REQ-016 VGA_write  out  1  registered write strobe to the VGA adapter.
REQ-017 owner  out  3  index of the current grant holder; valid while busy=1.
REQ-018 busy  out  1  high while in BURST state.
REQ-019 clip_cnt  out  16  saturating count of clipped pixels.

Function
REQ-020 The FSM SHALL have exactly two states: IDLE and BURST.
REQ-021 In IDLE, if any req bit is high, the block SHALL choose requester k round-robin, searching from (ptr+1) mod N_REQ upward, then set gnt[k], owner=k and state BURST on the next edge.
REQ-022 In IDLE, with req all-zero, the block SHALL hold gnt at 0 and remain in IDLE.
REQ-023 In BURST, a pixel SHALL be accepted in each cycle with req[owner]=1 and gnt[owner]=1; the req bits and pixel data of non-owners SHALL be ignored.
REQ-024 An accepted in-frame pixel SHALL appear on VGA_x/VGA_y/VGA_color with VGA_write=1 exactly one cycle later (latency 1).
REQ-025 VGA_write SHALL be 0 in every cycle not following an accepted in-frame pixel; VGA_x/y/color SHALL hold their previous values in those cycles.
REQ-026 An accepted pixel with x>=H_RES or y>=V_RES SHALL be consumed with VGA_write=0 and SHALL increment clip_cnt, saturating at 16'hFFFF.
REQ-027 Burst counter: the counter SHALL reset to 0 on entry to BURST and increment on every BURST cycle, whether or not req is high.
REQ-028 Normal release: an accepted pixel with last[owner]=1 SHALL cause gnt to clear, ptr<=owner and state IDLE on the next edge; that pixel is still written.
REQ-029 Forced release: when the burst counter equals MAX_BURST-1, release SHALL occur as in REQ-028 even without last.
REQ-030 When the owner drops req without last, the grant SHALL be held until last or forced release.
REQ-031 Every release SHALL be followed by at least one IDLE cycle with gnt=0 before the next grant.
REQ-032 With several req bits rising simultaneously, exactly one grant SHALL issue, per REQ-021.
REQ-033 The selection input SHALL be ignored for requester indices at or above N_REQ; owner SHALL use the low bits for N_REQ<8.

Reset
REQ-034 Resetn=0 SHALL immediately force: state IDLE, gnt 0, owner 0, busy 0, VGA_write 0, VGA_x/y/color 0, clip_cnt 0, burst counter 0, and ptr=N_REQ-1, so that requester 0 has first priority.
REQ-035 Reset asserted mid-burst SHALL abort the burst with no further VGA_write; after release, arbitration SHALL restart as from power-up.

Structure
REQ-036 A shared package SHALL hold nX, nY, COLOR_DEPTH, H_RES, V_RES and the IDLE/BURST state encoding, shared with the player and obstacle objects.
REQ-037 The round-robin priority search SHALL be one combinational sub-module, rr_pick (inputs req and ptr; outputs the one-hot pick and its index, plus a valid flag).

Verification
REQ-038 Reset, then req=4'b0001 with pixel (100,200,9'h1C0) and last=1 -> gnt[0] after 1 cycle; VGA write of (100,200,9'h1C0) 1 cycle after acceptance; then IDLE.
REQ-039 req=4'b1111 raised together, each sending 2-pixel bursts -> grant order 0,1,2,3,0 with one IDLE gap between bursts.
REQ-040 Owner 2 sends 3 pixels, drops req for 5 cycles, then sends 1 pixel with last -> gnt[2] held throughout; exactly 4 VGA writes; no other grant.
REQ-041 MAX_BURST=8, owner 1 sends continuously without last -> forced release after 8 BURST cycles; 8 writes; next grant goes to requester 2 if requesting.
REQ-042 Pixels at (640,10) and (5,480) accepted -> VGA_write stays 0; clip_cnt=2.
REQ-043 Resetn pulsed low during a 10-pixel burst -> VGA_write and gnt go 0 asynchronously; first grant after reset goes to the lowest requesting index.
